// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with wrap/saturate boundaries, synchronous load,
// boundary flags, a wrap event pulse and sticky overflow/underflow flags.
module param_up_down_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_C = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  logic             step_up;
  logic             step_dn;
  logic             bound_up;
  logic             bound_dn;
  logic [WIDTH-1:0] load_clip;
  logic [WIDTH-1:0] count_nxt;

  always_comb begin
    at_max  = (count == MAX_C);
    at_zero = (count == '0);
  end

  // Boundary detection compares against MAX_VAL, never the natural rollover.
  always_comb begin
    step_up   = ~load & en & up_down;
    step_dn   = ~load & en & ~up_down;
    bound_up  = step_up & at_max;
    bound_dn  = step_dn & at_zero;
    load_clip = (load_val > MAX_C) ? MAX_C : load_val;
    count_nxt = count;
    if (load) begin
      count_nxt = load_clip;
    end else if (step_up) begin
      if (!at_max)        count_nxt = count + ONE_C;
      else if (!SATURATE) count_nxt = '0;
    end else if (step_dn) begin
      if (!at_zero)       count_nxt = count - ONE_C;
      else if (!SATURATE) count_nxt = MAX_C;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= bound_up | bound_dn;
      // A setting event on the same edge as clr_flags wins.
      ovf   <= bound_up | (ovf & ~clr_flags);
      unf   <= bound_dn | (unf & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_param_up_down_counter.sv
// Bench for param_up_down_counter: three instances (wrap, saturate, MAX_VAL=1)
// checked every cycle against an arithmetic model plus literal expectations.
module tb_param_up_down_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       up_down = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       clr_flags = 1'b0;

  logic [3:0] c0, c1;
  logic [1:0] c2;
  logic       am0, am1, am2, az0, az1, az2;
  logic       w0, w1, w2, o0, o1, o2, u0, u1, u2;

  int tests = 0;
  int failed = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  param_up_down_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) d0 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .clr_flags(clr_flags), .count(c0), .at_max(am0),
    .at_zero(az0), .wrap(w0), .ovf(o0), .unf(u0));

  param_up_down_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) d1 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .clr_flags(clr_flags), .count(c1), .at_max(am1),
    .at_zero(az1), .wrap(w1), .ovf(o1), .unf(u1));

  param_up_down_counter #(.WIDTH(2), .MAX_VAL(1), .SATURATE(1'b0)) d2 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val[1:0]), .clr_flags(clr_flags), .count(c2), .at_max(am2),
    .at_zero(az2), .wrap(w2), .ovf(o2), .unf(u2));

  // Model configuration per instance
  int mx[3]   = '{9, 9, 1};
  int msk[3]  = '{15, 15, 3};
  bit sat[3]  = '{1'b0, 1'b1, 1'b0};

  int m_cnt[3];
  bit m_wrap[3], m_ovf[3], m_unf[3];

  logic [31:0] a_cnt[3];
  logic        a_am[3], a_az[3], a_w[3], a_o[3], a_u[3];
  assign a_cnt[0] = 32'(c0);
  assign a_cnt[1] = 32'(c1);
  assign a_cnt[2] = 32'(c2);
  assign a_am = '{am0, am1, am2};
  assign a_az = '{az0, az1, az2};
  assign a_w  = '{w0, w1, w2};
  assign a_o  = '{o0, o1, o2};
  assign a_u  = '{u0, u1, u2};

  always @(posedge clk or posedge reset) begin : model
    int lv;
    bit oset, uset;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_cnt[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
      end else begin
        lv = int'(load_val) & msk[i];
        oset = 0; uset = 0;
        if (load) begin
          m_cnt[i] = (lv > mx[i]) ? mx[i] : lv;
        end else if (en && up_down) begin
          oset = (m_cnt[i] == mx[i]);
          m_cnt[i] = sat[i] ? ((m_cnt[i] + 1 > mx[i]) ? mx[i] : m_cnt[i] + 1)
                            : (m_cnt[i] + 1) % (mx[i] + 1);
        end else if (en) begin
          uset = (m_cnt[i] == 0);
          m_cnt[i] = sat[i] ? ((m_cnt[i] == 0) ? 0 : m_cnt[i] - 1)
                            : (m_cnt[i] + mx[i]) % (mx[i] + 1);
        end
        m_wrap[i] = oset | uset;
        m_ovf[i]  = oset | (m_ovf[i] & !clr_flags);
        m_unf[i]  = uset | (m_unf[i] & !clr_flags);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("model_cnt[%0d]", i), a_cnt[i], 32'(m_cnt[i]));
        check($sformatf("model_at_max[%0d]", i), 32'(a_am[i]), 32'(m_cnt[i] == mx[i]));
        check($sformatf("model_at_zero[%0d]", i), 32'(a_az[i]), 32'(m_cnt[i] == 0));
        check($sformatf("model_wrap[%0d]", i), 32'(a_w[i]), 32'(m_wrap[i]));
        check($sformatf("model_ovf[%0d]", i), 32'(a_o[i]), 32'(m_ovf[i]));
        check($sformatf("model_unf[%0d]", i), 32'(a_u[i]), 32'(m_unf[i]));
      end
    end
  end

  // Inputs change just after a falling edge; results are visible at the next falling edge.
  task automatic drive(input bit e, input bit ud, input bit ld, input logic [3:0] lv, input bit clr);
    en = e; up_down = ud; load = ld; load_val = lv; clr_flags = clr;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checking = 1'b1;
    check("reset_count", 32'(c0), 0);
    check("reset_at_zero", 32'(az0), 1);
    check("reset_at_max", 32'(am0), 0);
    check("reset_flags", 32'({w0, o0, u0}), 0);
    reset = 1'b0;

    // T1: wrap-mode up count through the boundary
    for (int k = 0; k < 12; k++) begin
      drive(1, 1, 0, 0, 0);
      check("t1_count", 32'(c0), 32'((k + 1) % 10));
      check("t1_wrap", 32'(w0), 32'(k == 9));
    end
    check("t1_ovf", 32'(o0), 1);
    check("t1_sat_count", 32'(c1), 9);

    // T2: down through zero
    drive(0, 0, 1, 4'd0, 0);
    drive(1, 0, 0, 0, 0);
    check("t2_count_a", 32'(c0), 9);
    check("t2_wrap_a", 32'(w0), 1);
    check("t2_unf", 32'(u0), 1);
    drive(1, 0, 0, 0, 0);
    check("t2_count_b", 32'(c0), 8);
    check("t2_wrap_b", 32'(w0), 0);

    // T3: saturating hold at MAX_VAL
    drive(0, 0, 1, 4'd8, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 0, 0);
      check("t3_count", 32'(c1), 9);
      check("t3_wrap", 32'(w1), 32'(k != 0));
    end
    check("t3_at_max", 32'(am1), 1);

    // T4: load beats enable, load value clipped
    drive(1, 1, 1, 4'd15, 0);
    check("t4_clip", 32'(c0), 9);
    check("t4_clip_w2", 32'(c2), 1);
    check("t4_wrap", 32'(w0), 0);
    drive(0, 0, 1, 4'd5, 0);
    check("t4_load5", 32'(c0), 5);

    // T5: set beats clear on the same edge
    drive(0, 0, 1, 4'd9, 0);
    drive(1, 1, 0, 0, 1);
    check("t5_count", 32'(c0), 0);
    check("t5_ovf_set_wins", 32'(o0), 1);
    check("t5_wrap", 32'(w0), 1);
    drive(0, 0, 0, 0, 1);
    check("t5_ovf_cleared", 32'(o0), 0);
    check("t5_unf_cleared", 32'(u0), 0);

    // T6: asynchronous reset between edges
    drive(0, 0, 1, 4'd9, 0);
    drive(1, 1, 0, 0, 0);
    drive(0, 0, 1, 4'd7, 0);
    check("t6_count_pre", 32'(c0), 7);
    check("t6_ovf_kept_by_load", 32'(o0), 1);
    en = 1'b1; up_down = 1'b1; load = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("t6_async_count", 32'(c0), 0);
    check("t6_async_flags", 32'({w0, o0, u0}), 0);
    check("t6_async_at_zero", 32'(az0), 1);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 1, 0, 0, 0);
    check("t6_resume", 32'(c0), 1);

    // Degenerate MAX_VAL=1 instance
    drive(0, 0, 1, 4'd0, 1);
    drive(1, 1, 0, 0, 0);
    check("t7_count_a", 32'(c2), 1);
    check("t7_wrap_a", 32'(w2), 0);
    drive(1, 1, 0, 0, 0);
    check("t7_count_b", 32'(c2), 0);
    check("t7_wrap_b", 32'(w2), 1);

    // Mixed traffic checked by the model
    for (int k = 0; k < 80; k++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0));
    end

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
